// File: rtl/spi_flash_arbiter.sv
// Arbitrates two requesters onto one SPI byte engine and one flash chip select.
// Round-robin grant per transaction, registered strobe forwarding, guaranteed
// chip-select high time between transactions, protocol-error pulse on bad strobes.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req0_i/req1_i            requester holds high for a whole transaction
//   gnt0_o/gnt1_o            requester owns engine and chip select
//   send*_i/recv*_i/din*_i   per-requester byte strobes and transmit data
//   ready0_o/ready1_o        owner may issue the next strobe; dout_o valid
//   dout_o                   received byte (pass-through of eng_dout_i)
//   eng_send_o/eng_recv_o    registered strobes to the byte engine
//   eng_din_o                byte to the engine
//   eng_dout_i, eng_ready_i  byte from the engine, engine idle
//   spi_cs_o                 flash chip select, active-low, registered
//   proto_err_o              one-cycle pulse on an illegal owner strobe
module spi_flash_arbiter #(
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_i,
  input  logic       req1_i,
  output logic       gnt0_o,
  output logic       gnt1_o,
  input  logic       send0_i,
  input  logic       send1_i,
  input  logic       recv0_i,
  input  logic       recv1_i,
  input  logic [7:0] din0_i,
  input  logic [7:0] din1_i,
  output logic       ready0_o,
  output logic       ready1_o,
  output logic [7:0] dout_o,
  output logic       eng_send_o,
  output logic       eng_recv_o,
  output logic [7:0] eng_din_o,
  input  logic [7:0] eng_dout_i,
  input  logic       eng_ready_i,
  output logic       spi_cs_o,
  output logic       proto_err_o
);

  typedef enum logic [2:0] {StIdle, StSetup, StActive, StDrain, StGap} state_e;

  // Power-up values match the reset values.
  state_e      state_q    = StIdle;
  logic        owner_q    = 1'b0;
  logic        last_q     = 1'b1;
  logic [1:0]  gnt_q      = 2'b00;
  logic        cs_q       = 1'b1;
  logic        eng_send_q = 1'b0;
  logic        eng_recv_q = 1'b0;
  logic [7:0]  eng_din_q  = 8'h00;
  logic        perr_q     = 1'b0;
  logic [7:0]  gap_q      = 8'h00;
  logic        issued_q   = 1'b0;

  state_e      state_d;
  logic        owner_d, last_d, cs_d, eng_send_d, eng_recv_d, perr_d, issued_d;
  logic [1:0]  gnt_d;
  logic [7:0]  eng_din_d, gap_d;

  logic        own_req, own_send, own_recv, in_flight, ready_own, pick;
  logic [7:0]  own_din;

  assign own_req  = owner_q ? req1_i  : req0_i;
  assign own_send = owner_q ? send1_i : send0_i;
  assign own_recv = owner_q ? recv1_i : recv0_i;
  assign own_din  = owner_q ? din1_i  : din0_i;

  // A strobe is "in flight" while the engine strobe is out and for one cycle
  // after, covering the engine's latency in dropping eng_ready_i.
  assign in_flight = eng_send_q | eng_recv_q | issued_q;
  assign ready_own = (state_q == StActive) && eng_ready_i && !in_flight;

  // Tie goes to the requester not granted last; a lone request always wins.
  assign pick = (req0_i && req1_i) ? ~last_q : req1_i;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    cs_d       = cs_q;
    eng_send_d = 1'b0;
    eng_recv_d = 1'b0;
    eng_din_d  = eng_din_q;
    perr_d     = 1'b0;
    gap_d      = gap_q;
    issued_d   = eng_send_q | eng_recv_q;

    case (state_q)
      StIdle: begin
        if (req0_i || req1_i) begin
          owner_d = pick;
          last_d  = pick;
          cs_d    = 1'b0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        gnt_d   = owner_q ? 2'b10 : 2'b01;
        state_d = StActive;
      end
      StActive: begin
        if (own_send || own_recv) begin
          if (!ready_own) begin
            perr_d = 1'b1;
          end else if (own_send) begin
            eng_send_d = 1'b1;
            eng_din_d  = own_din;
            perr_d     = own_recv;  // simultaneous recv is dropped
          end else begin
            eng_recv_d = 1'b1;
          end
        end
        if (!own_req) begin
          if (ready_own && !own_send && !own_recv) begin
            cs_d    = 1'b1;
            gnt_d   = 2'b00;
            gap_d   = 8'(GAP_CYCLES);
            state_d = StGap;
          end else begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (eng_ready_i && !in_flight) begin
          cs_d    = 1'b1;
          gnt_d   = 2'b00;
          gap_d   = 8'(GAP_CYCLES);
          state_d = StGap;
        end
      end
      StGap: begin
        gap_d = gap_q - 8'd1;
        if (gap_q <= 8'd1) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      gnt_q      <= 2'b00;
      cs_q       <= 1'b1;
      eng_send_q <= 1'b0;
      eng_recv_q <= 1'b0;
      eng_din_q  <= 8'h00;
      perr_q     <= 1'b0;
      gap_q      <= 8'h00;
      issued_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      cs_q       <= cs_d;
      eng_send_q <= eng_send_d;
      eng_recv_q <= eng_recv_d;
      eng_din_q  <= eng_din_d;
      perr_q     <= perr_d;
      gap_q      <= gap_d;
      issued_q   <= issued_d;
    end
  end

  assign gnt0_o      = gnt_q[0];
  assign gnt1_o      = gnt_q[1];
  assign ready0_o    = ready_own && !owner_q;
  assign ready1_o    = ready_own && owner_q;
  assign dout_o      = eng_dout_i;
  assign eng_send_o  = eng_send_q;
  assign eng_recv_o  = eng_recv_q;
  assign eng_din_o   = eng_din_q;
  assign spi_cs_o    = cs_q;
  assign proto_err_o = perr_q;

endmodule
